// File: rtl/circle_raster_pkg.sv
// Shared types and helpers for the circle rasteriser.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package circle_raster_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int FB_W_DEF = 640;
  localparam int FB_H_DEF = 480;

  // dx*dx + dy*dy with |dx|,|dy| < 2^coord_w cannot overflow this width.
  function automatic int d2_width(input int coord_w);
    return 2 * (coord_w + 1) + 1;
  endfunction

  localparam int D2_W_DEF = d2_width(10);

  // Linear framebuffer address, row-major.
  function automatic logic [31:0] pix_addr(input logic [31:0] x,
                                           input logic [31:0] y,
                                           input logic [31:0] fb_w);
    return y * fb_w + x;
  endfunction

endpackage

// File: rtl/circle_raster_cover.sv
// Coverage test for one scan pixel: squared distance to the centre vs r^2 (and inner ring bound).
// Latency: 1 cycle (combinational d2/compare, result registered).
// Backpressure: en=0 freezes the register so a waiting covered pixel is not lost.
// Ports: clk/rst_n; en, in_vld; x,y pixel; cx,cy centre; r2 = r*r;
//        r2_inner/outline only with CIRCLE_RASTER_OUTLINE_EN; p_vld/p_cov/p_x/p_y registered result.
module circle_raster_cover
  import circle_raster_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int D2_W    = D2_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_vld,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic [D2_W-1:0]    r2,
`ifdef CIRCLE_RASTER_OUTLINE_EN
  input  logic [D2_W-1:0]    r2_inner,
  input  logic               outline,  // ring test active (outline requested and r >= THICK)
`endif
  output logic               p_vld,
  output logic               p_cov,
  output logic [COORD_W-1:0] p_x,
  output logic [COORD_W-1:0] p_y
);

  logic signed [D2_W-1:0] dx;
  logic signed [D2_W-1:0] dy;
  logic [D2_W-1:0]        d2;
  logic                   cov;

  always_comb begin
    dx = D2_W'($signed({1'b0, x}) - $signed({1'b0, cx}));
    dy = D2_W'($signed({1'b0, y}) - $signed({1'b0, cy}));
    d2 = $unsigned(dx * dx + dy * dy);
`ifdef CIRCLE_RASTER_OUTLINE_EN
    cov = (d2 <= r2) && (!outline || (d2 > r2_inner));
`else
    cov = (d2 <= r2);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_vld <= 1'b0;
      p_cov <= 1'b0;
      p_x   <= '0;
      p_y   <= '0;
    end else if (en) begin
      p_vld <= in_vld;
      p_cov <= in_vld && cov;
      p_x   <= x;
      p_y   <= y;
    end
  end

endmodule

// File: rtl/circle_raster.sv
// Circle rasteriser: scans the clipped bounding box and emits framebuffer writes for covered pixels.
// Latency: start -> SETUP (1) -> SCAN; a pixel reaches wr_valid 2 cycles after being scanned; 1 px/clk.
// Backpressure: wr_valid/wr_ready; scanner stalls only when a covered pixel meets a stuck output register.
// Ports: clk, rst_n; start, cx, cy, radius, color, outline (command); busy, done (status);
//        wr_valid, wr_ready, wr_addr, wr_data (framebuffer write port).
// Option: CIRCLE_RASTER_OUTLINE_EN enables ring mode (outline=1); without it outline is ignored.
module circle_raster
  import circle_raster_pkg::*;
#(
  parameter int FB_W    = FB_W_DEF,
  parameter int FB_H    = FB_H_DEF,
  parameter int COORD_W = 10,
  parameter int R_W     = 9,
  parameter int PIX_W   = 24,
  parameter int ADDR_W  = 19,
  parameter int THICK   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic [R_W-1:0]     radius,
  input  logic [PIX_W-1:0]   color,
  input  logic               outline,
  output logic               busy,
  output logic               done,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [PIX_W-1:0]   wr_data
);

  localparam int D2_W = d2_width(COORD_W);
  localparam int SW   = COORD_W + 2;
  localparam logic signed [SW-1:0] X_MAX = SW'(FB_W - 1);
  localparam logic signed [SW-1:0] Y_MAX = SW'(FB_H - 1);

  state_t             state;
  logic [COORD_W-1:0] cx_l, cy_l;
  logic [R_W-1:0]     r_l;
  logic [PIX_W-1:0]   col_l;
  logic [COORD_W-1:0] x0, x1, y1, sx, sy;
  logic [D2_W-1:0]    r2;
`ifdef CIRCLE_RASTER_OUTLINE_EN
  logic               outl_l;
  logic               ring;
  logic [D2_W-1:0]    r2_inner;
`else
  // outline and THICK only matter with the ring option compiled in.
  logic               unused_cfg;
  assign unused_cfg = outline ^ (THICK != 0);
`endif

  // Clipped bounding box from the latched command, signed so cx-r may go negative.
  logic signed [SW-1:0] cxs, cys, rs, lo_x, hi_x, lo_y, hi_y;
  logic signed [SW-1:0] x0_s, x1_s, y0_s, y1_s;
  logic                 off_screen;

  always_comb begin
    cxs  = $signed(SW'(cx_l));
    cys  = $signed(SW'(cy_l));
    rs   = $signed(SW'(r_l));
    lo_x = cxs - rs;
    hi_x = cxs + rs;
    lo_y = cys - rs;
    hi_y = cys + rs;
    x0_s = (lo_x < 0) ? '0 : lo_x;
    x1_s = (hi_x > X_MAX) ? X_MAX : hi_x;
    y0_s = (lo_y < 0) ? '0 : lo_y;
    y1_s = (hi_y > Y_MAX) ? Y_MAX : hi_y;
    off_screen = (x0_s > x1_s) || (y0_s > y1_s);
  end

  logic               p_vld, p_cov;
  logic [COORD_W-1:0] p_x, p_y;
  logic               stall;

  // Only a covered pixel needs the output slot; uncovered ones flow through.
  assign stall = p_vld && p_cov && wr_valid && !wr_ready;

  circle_raster_cover #(
    .COORD_W (COORD_W),
    .D2_W    (D2_W)
  ) u_cover (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (!stall),
    .in_vld   (state == ST_SCAN),
    .x        (sx),
    .y        (sy),
    .cx       (cx_l),
    .cy       (cy_l),
    .r2       (r2),
`ifdef CIRCLE_RASTER_OUTLINE_EN
    .r2_inner (r2_inner),
    .outline  (ring),
`endif
    .p_vld    (p_vld),
    .p_cov    (p_cov),
    .p_x      (p_x),
    .p_y      (p_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      cx_l     <= '0;
      cy_l     <= '0;
      r_l      <= '0;
      col_l    <= '0;
      x0       <= '0;
      x1       <= '0;
      y1       <= '0;
      sx       <= '0;
      sy       <= '0;
      r2       <= '0;
`ifdef CIRCLE_RASTER_OUTLINE_EN
      outl_l   <= 1'b0;
      ring     <= 1'b0;
      r2_inner <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            cx_l  <= cx;
            cy_l  <= cy;
            r_l   <= radius;
            col_l <= color;
`ifdef CIRCLE_RASTER_OUTLINE_EN
            outl_l <= outline;
`endif
            busy  <= 1'b1;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          x0 <= x0_s[COORD_W-1:0];
          x1 <= x1_s[COORD_W-1:0];
          y1 <= y1_s[COORD_W-1:0];
          sx <= x0_s[COORD_W-1:0];
          sy <= y0_s[COORD_W-1:0];
          r2 <= D2_W'(r_l) * D2_W'(r_l);
`ifdef CIRCLE_RASTER_OUTLINE_EN
          // r < THICK: ring would swallow the centre, so fall back to fill.
          ring     <= outl_l && (r_l >= R_W'(THICK));
          r2_inner <= D2_W'(r_l - R_W'(THICK)) * D2_W'(r_l - R_W'(THICK));
`endif
          done  <= off_screen;
          state <= off_screen ? ST_DONE : ST_SCAN;
        end
        ST_SCAN: begin
          if (!stall) begin
            if (sx == x1) begin
              sx <= x0;
              if (sy == y1) state <= ST_DRAIN;
              else          sy    <= sy + 1'b1;
            end else begin
              sx <= sx + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // Pipeline empty and the output register empties at this edge.
          if (!p_vld && (!wr_valid || wr_ready)) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output register: reloads in the same cycle it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else if (!wr_valid || wr_ready) begin
      wr_valid <= p_vld && p_cov;
      if (p_vld && p_cov) begin
        wr_addr <= ADDR_W'(pix_addr(32'(p_x), 32'(p_y), 32'(FB_W)));
        wr_data <= col_l;
      end
    end
  end

endmodule
